tx_packet_framer: RTL and testbench

Sits between the frame byte buffer (`tx_ram`) and the UART TX FIFO (`uart_tx_fifo`), and wraps each packed Canny edge frame into a self-delimiting packet for the pen-plotter host. Once a complete frame is buffered, it emits the following sequence, throttled by FIFO back-pressure:

- sync byte pair
- 16-bit big-endian payload length
- payload bytes, read sequentially from the buffer
- 8-bit additive checksum

It then acknowledges the buffer so the next frame can be written.

---
 rtl/tx_framer_pkg.sv | 20 ++
 rtl/tx_packet_framer.sv | 99 +++++++++
 tb/tb_tx_packet_framer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_framer_pkg.sv
// tx_framer_pkg: state encoding and framing constants shared by the packet framer.
package tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_CKSUM,
        ST_DONE
    } framer_state_t;

    localparam logic [7:0] DEF_SYNC0 = 8'hAA;
    localparam logic [7:0] DEF_SYNC1 = 8'h55;
    localparam int         HDR_BYTES = 4;
    localparam int         TRL_BYTES = 1;

endpackage

// File: rtl/tx_packet_framer.sv
// tx_packet_framer: wraps a buffered frame as sync + length + payload + checksum
// and streams it into the UART TX FIFO under back-pressure.
module tx_packet_framer
    import tx_framer_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 5100,
    parameter logic [7:0] SYNC0         = DEF_SYNC0,
    parameter logic [7:0] SYNC1         = DEF_SYNC1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_ready,
    output logic                             frame_ack,
    output logic                             ram_re,
    output logic [$clog2(PAYLOAD_BYTES)-1:0] ram_addr,
    input  logic [7:0]                       ram_rdata,
    input  logic                             fifo_full,
    output logic                             fifo_push,
    output logic [7:0]                       fifo_data,
    output logic                             busy
);

    localparam int            AW   = $clog2(PAYLOAD_BYTES);
    localparam int            CW   = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BYTES);
    localparam logic [15:0]   LEN  = 16'(PAYLOAD_BYTES);

    framer_state_t state_q, state_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          pend_q, pend_d;
    logic          hold_v_q, hold_v_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    cksum_q, cksum_d;
    logic          in_pay, avail, more, pay_push, pay_done;

    always_comb begin
        in_pay = state_q == ST_PAYLOAD;
        avail  = in_pay ? hold_v_q
                        : state_q inside {ST_SYNC0, ST_SYNC1, ST_LEN_HI, ST_LEN_LO, ST_CKSUM};
        case (state_q)
            ST_SYNC0:   fifo_data = SYNC0;
            ST_SYNC1:   fifo_data = SYNC1;
            ST_LEN_HI:  fifo_data = LEN[15:8];
            ST_LEN_LO:  fifo_data = LEN[7:0];
            ST_PAYLOAD: fifo_data = hold_q;
            ST_CKSUM:   fifo_data = cksum_q;
            default:    fifo_data = '0;
        endcase
        fifo_push = avail && !fifo_full;
        pay_push  = in_pay && fifo_push;
        more      = rd_cnt_q < LAST;
        // A new read is only issued once the holding slot is free or draining now
        ram_re    = in_pay && more && !pend_q && (!hold_v_q || fifo_push);
        ram_addr  = rd_cnt_q[AW-1:0];
        pay_done  = !more && !pend_q && (!hold_v_q || fifo_push);
        frame_ack = state_q == ST_CKSUM && fifo_push;
        busy      = state_q != ST_IDLE;
        pend_d    = ram_re;
        rd_cnt_d  = rd_cnt_q + CW'(ram_re);
        hold_d    = pend_q ? ram_rdata : hold_q;
        hold_v_d  = pend_q || (hold_v_q && !pay_push);
        cksum_d   = pay_push ? cksum_q + hold_q : cksum_q;
        state_d   = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d  = frame_ready ? ST_SYNC0 : ST_IDLE;
                rd_cnt_d = '0;
                hold_v_d = 1'b0;
                cksum_d  = '0;
            end
            ST_SYNC0:   state_d = fifo_push ? ST_SYNC1 : ST_SYNC0;
            ST_SYNC1:   state_d = fifo_push ? ST_LEN_HI : ST_SYNC1;
            ST_LEN_HI:  state_d = fifo_push ? ST_LEN_LO : ST_LEN_HI;
            ST_LEN_LO:  state_d = fifo_push ? ST_PAYLOAD : ST_LEN_LO;
            ST_PAYLOAD: state_d = pay_done ? ST_CKSUM : ST_PAYLOAD;
            ST_CKSUM:   state_d = fifo_push ? ST_DONE : ST_CKSUM;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= '0;
            pend_q   <= 1'b0;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            cksum_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            pend_q   <= pend_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            cksum_q  <= cksum_d;
        end
    end

endmodule

// File: tb/tb_tx_packet_framer.sv
// tb_tx_packet_framer: directed checks of a 4-byte framer and a default-size framer.
module tb_tx_packet_framer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        fr_a, ack_a, re_a, full_a, push_a, busy_a;
    logic [1:0]  addr_a;
    logic [7:0]  rdata_a, data_a;
    logic        fr_b, ack_b, re_b, full_b, push_b, busy_b;
    logic [12:0] addr_b;
    logic [7:0]  rdata_b, data_b;
    logic [7:0]  mem_a [4];

    tx_packet_framer #(.PAYLOAD_BYTES(4)) dut_a (
        .clk(clk), .reset(reset), .frame_ready(fr_a), .frame_ack(ack_a),
        .ram_re(re_a), .ram_addr(addr_a), .ram_rdata(rdata_a),
        .fifo_full(full_a), .fifo_push(push_a), .fifo_data(data_a), .busy(busy_a)
    );

    tx_packet_framer dut_b (
        .clk(clk), .reset(reset), .frame_ready(fr_b), .frame_ack(ack_b),
        .ram_re(re_b), .ram_addr(addr_b), .ram_rdata(rdata_b),
        .fifo_full(full_b), .fifo_push(push_b), .fifo_data(data_b), .busy(busy_b)
    );

    always_ff @(posedge clk) if (re_a) rdata_a <= mem_a[addr_a];
    always_ff @(posedge clk) if (re_b) rdata_b <= addr_b[7:0];

    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    int          viol, acks_a, acks_b, busy_cyc, re_b_cnt, addr_err;
    logic [12:0] exp_addr_b;
    int          checks = 0;
    int          passed = 0;

    always @(negedge clk) begin
        if (push_a) q_a.push_back(data_a);
        if (push_a && full_a) viol++;
        if (ack_a) acks_a++;
        if (busy_a) busy_cyc++;
        if (push_b) q_b.push_back(data_b);
        if (ack_b) acks_b++;
        if (re_b) begin
            if (addr_b != exp_addr_b) addr_err++;
            exp_addr_b++;
            re_b_cnt++;
        end
    end

    typedef struct {
        logic       fr;
        logic       push;
        logic [7:0] data;
        logic       ack;
        logic       busy;
        logic       re;
        logic [1:0] addr;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic clear_mon();
        q_a.delete();
        viol     = 0;
        acks_a   = 0;
        busy_cyc = 0;
    endtask

    task automatic wait_acks(input int n, input bit rnd, input string name);
        int k = 0;
        while (acks_a < n && k < 400) begin
            full_a = rnd ? ($urandom_range(0, 99) < 60) : 1'b0;
            @(posedge clk); #1;
            k++;
        end
        full_a = 1'b0;
        chk({name, "_ack_seen"}, 32'(acks_a >= n), 1);
    endtask

    task automatic chk_stream_a(input string name, input int base);
        logic [7:0] e [9];
        logic [7:0] s = 8'h00;
        e[0] = 8'hAA; e[1] = 8'h55; e[2] = 8'h00; e[3] = 8'h04;
        for (int i = 0; i < 4; i++) begin
            e[4+i] = mem_a[i];
            s      = s + mem_a[i];
        end
        e[8] = s;
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(q_a[base+i]), 32'(e[i]));
    endtask

    task automatic pulse_a();
        fr_a = 1'b1;
        @(posedge clk); #1;
        fr_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fr_a = 1'b0; full_a = 1'b0; fr_b = 1'b0; full_b = 1'b0;
        exp_addr_b = '0; re_b_cnt = 0; addr_err = 0; acks_b = 0;
        mem_a[0] = 8'h01; mem_a[1] = 8'h02; mem_a[2] = 8'h03; mem_a[3] = 8'hFF;
        clear_mon();
        tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
        tv[1]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[2]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[4]  = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0};
        tv[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd1};
        tv[7]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 2'd1};
        tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd2};
        tv[9]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 2'd2};
        tv[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd3};
        tv[11] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 2'd3};
        tv[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[13] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[14] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 2'd0};
        tv[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};

        repeat (2) @(negedge clk);
        chk("rst_push_a", 32'(push_a), 0);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_re_a", 32'(re_a), 0);
        chk("rst_ack_a", 32'(ack_a), 0);
        chk("rst_data_a", 32'(data_a), 0);
        chk("rst_addr_a", 32'(addr_a), 0);
        chk("rst_push_b", 32'(push_b), 0);
        chk("rst_busy_b", 32'(busy_b), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        clear_mon();

        for (int i = 0; i < 17; i++) begin
            fr_a = tv[i].fr;
            @(negedge clk);
            chk($sformatf("tv%0d_push", i), 32'(push_a), 32'(tv[i].push));
            chk($sformatf("tv%0d_busy", i), 32'(busy_a), 32'(tv[i].busy));
            chk($sformatf("tv%0d_ack", i), 32'(ack_a), 32'(tv[i].ack));
            chk($sformatf("tv%0d_re", i), 32'(re_a), 32'(tv[i].re));
            if (tv[i].push) chk($sformatf("tv%0d_data", i), 32'(data_a), 32'(tv[i].data));
            if (tv[i].re) chk($sformatf("tv%0d_addr", i), 32'(addr_a), 32'(tv[i].addr));
            @(posedge clk); #1;
        end
        chk("tv_ack_count", acks_a, 1);
        chk("tv_len", q_a.size(), 9);

        clear_mon();
        pulse_a();
        wait_acks(1, 1'b1, "rnd");
        repeat (3) @(posedge clk); #1;
        chk("rnd_len", q_a.size(), 9);
        chk("rnd_no_push_when_full", viol, 0);
        chk_stream_a("rnd", 0);

        clear_mon();
        pulse_a();
        begin
            int k = 0;
            while (q_a.size() < 6 && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("abort_reached_payload", q_a.size(), 6);
        reset = 1'b1;
        #1;
        chk("abort_push", 32'(push_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_re", 32'(re_a), 0);
        chk("abort_ack", 32'(ack_a), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_no_ack", acks_a, 0);
        @(posedge clk); #1;
        clear_mon();
        pulse_a();
        wait_acks(1, 1'b0, "restart");
        repeat (3) @(posedge clk); #1;
        chk("restart_len", q_a.size(), 9);
        chk_stream_a("restart", 0);

        clear_mon();
        fr_a = 1'b1;
        wait_acks(1, 1'b0, "hold1");
        @(posedge clk); #1;
        fr_a = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("hold1_acks", acks_a, 1);
        chk("hold1_len", q_a.size(), 9);

        clear_mon();
        fr_a = 1'b1;
        wait_acks(1, 1'b0, "hold2a");
        @(posedge clk); #1;
        @(posedge clk); #1;
        fr_a = 1'b0;
        wait_acks(2, 1'b0, "hold2b");
        repeat (3) @(posedge clk); #1;
        chk("hold2_acks", acks_a, 2);
        chk("hold2_len", q_a.size(), 18);
        chk_stream_a("hold2", 9);

        for (int i = 0; i < 4; i++) mem_a[i] = 8'h00;
        clear_mon();
        pulse_a();
        wait_acks(1, 1'b0, "zero");
        repeat (3) @(posedge clk); #1;
        chk("zero_len", q_a.size(), 9);
        chk("zero_cksum", 32'(q_a[8]), 0);
        chk("zero_busy_cycles", busy_cyc, 15);
        chk("zero_busy_after", 32'(busy_a), 0);

        q_b.delete();
        fr_b = 1'b1;
        @(posedge clk); #1;
        fr_b = 1'b0;
        begin
            int k = 0;
            while (acks_b < 1 && k < 12000) begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("def_ack_seen", 32'(acks_b >= 1), 1);
        repeat (3) @(posedge clk); #1;
        chk("def_len", q_b.size(), 5105);
        chk("def_sync0", 32'(q_b[0]), 32'h0AA);
        chk("def_sync1", 32'(q_b[1]), 32'h055);
        chk("def_len_hi", 32'(q_b[2]), 32'h013);
        chk("def_len_lo", 32'(q_b[3]), 32'h0EC);
        begin
            int bad = 0;
            for (int i = 0; i < 5100; i++)
                if (q_b[4+i] != 8'(i)) bad++;
            chk("def_payload_errors", bad, 0);
        end
        chk("def_cksum", 32'(q_b[5104]), 32'h0D2);
        chk("def_reads", re_b_cnt, 5100);
        chk("def_addr_errors", addr_err, 0);
        chk("def_acks", acks_b, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
